// File: rtl/branch_pkg.sv
// Shared types, constants and the saturating-counter helper for the branch
// predictor. CTR_BITS is the default counter width; the helper works on any
// width up to CTR_BITS_MAX so a resized table can reuse it.
package branch_pkg;

    localparam int CTR_BITS     = 2;
    localparam int CTR_BITS_MAX = 4;

    typedef logic [CTR_BITS-1:0] ctr_t;

    // Strongly taken and weakly not-taken at the default width.
    localparam ctr_t CTR_MAX  = '1;
    localparam ctr_t CTR_INIT = ctr_t'((1 << (CTR_BITS - 1)) - 1);

    typedef enum logic [0:0] {
        FLUSH_IDLE   = 1'b0,
        FLUSH_ACTIVE = 1'b1
    } flush_state_e;

    // Step a counter toward taken/not-taken, clamping at 0 and at max.
    function automatic logic [CTR_BITS_MAX-1:0] sat_update(
        input logic [CTR_BITS_MAX-1:0] ctr,
        input logic                    taken,
        input logic [CTR_BITS_MAX-1:0] max
    );
        logic [CTR_BITS_MAX-1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != max) nxt = ctr + 1'b1;
        end else begin
            if (ctr != '0) nxt = ctr - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_ctrl_bht_table.sv
// Saturating-counter table: one combinational read port for fetch, one
// update port from execute. A write is visible on the read port only from
// the following cycle (no bypass).
module bht_table
    import branch_pkg::*;
#(
    parameter int Depth   = 64,
    parameter int CtrBits = 2,
    parameter int IdxW    = $clog2(Depth)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IdxW-1:0]    rd_idx,
    output logic [CtrBits-1:0] rd_ctr,
    input  logic               wr_en,
    input  logic [IdxW-1:0]    wr_idx,
    input  logic               wr_taken
);

    localparam logic [CtrBits-1:0]      InitV = CtrBits'((1 << (CtrBits - 1)) - 1);
    localparam logic [CTR_BITS_MAX-1:0] MaxV  = CTR_BITS_MAX'((1 << CtrBits) - 1);

    logic [Depth-1:0][CtrBits-1:0] ctr_q;

    assign rd_ctr = ctr_q[rd_idx];

    // Reset every entry to weakly not-taken; otherwise train one entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= {Depth{InitV}};
        end else if (wr_en) begin
            ctr_q[wr_idx] <= CtrBits'(sat_update(CTR_BITS_MAX'(ctr_q[wr_idx]), wr_taken, MaxV));
        end
    end

endmodule

// File: rtl/branch_ctrl_bht.sv
// Branch predictor / controller: per-PC counter table, resolve-time training,
// mispredict flush with corrected PC, and branch/mispredict counters.
// Optional feature: define BRANCH_CTRL_GSHARE_EN to XOR a global history
// register into the table index.
module branch_ctrl_bht
    import branch_pkg::*;
#(
    parameter int WordSize = 32,
    parameter int Depth    = 64,
    parameter int CtrBits  = 2,
    parameter int FlushLen = 2,
    parameter int CntW     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WordSize-1:0] pred_pc,
    output logic                pred_taken,
    input  logic                res_valid,
    input  logic                res_is_branch,
    input  logic [WordSize-1:0] res_pc,
    input  logic                res_pred_taken,
    input  logic                res_act_taken,
    input  logic [WordSize-1:0] res_target,
    input  logic [WordSize-1:0] res_fallthrough,
    output logic                flush,
    output logic [WordSize-1:0] redirect_pc,
    output logic [CntW-1:0]     br_count,
    output logic [CntW-1:0]     mispred_count
);

    localparam int IdxW = $clog2(Depth);
    localparam int FcW  = $clog2(FlushLen + 1);

    flush_state_e        state_q, state_d;
    logic [FcW-1:0]      fcnt_q, fcnt_d;
    logic [WordSize-1:0] redir_q, redir_d;
    logic                squash, accept, mispred;
    logic [IdxW-1:0]     rd_idx, wr_idx;
    logic [CtrBits-1:0]  rd_ctr;

    // Anything resolving inside the flush window is wrong-path.
    assign squash  = (fcnt_q != '0);
    assign accept  = res_valid & res_is_branch & ~squash;
    assign mispred = accept & (res_pred_taken != res_act_taken);

`ifdef BRANCH_CTRL_GSHARE_EN
    logic [IdxW-1:0] ghr_q;

    // Shift the resolved outcome into history; the update index uses the
    // pre-shift value because the table write sees ghr_q this cycle.
    always_ff @(posedge clk) begin
        if (rst)         ghr_q <= '0;
        else if (accept) ghr_q <= IdxW'({ghr_q, res_act_taken});
    end

    assign rd_idx = pred_pc[IdxW+1:2] ^ ghr_q;
    assign wr_idx = res_pc[IdxW+1:2] ^ ghr_q;
`else
    assign rd_idx = pred_pc[IdxW+1:2];
    assign wr_idx = res_pc[IdxW+1:2];
`endif

    // Bits outside the index field do not participate in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[WordSize-1:IdxW+2], pred_pc[1:0],
                              res_pc[WordSize-1:IdxW+2], res_pc[1:0]};

    bht_table #(
        .Depth   (Depth),
        .CtrBits (CtrBits),
        .IdxW    (IdxW)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (accept),
        .wr_idx   (wr_idx),
        .wr_taken (res_act_taken)
    );

    assign pred_taken  = rd_ctr[CtrBits-1];
    assign flush       = squash;
    assign redirect_pc = redir_q;

    // Flush FSM state, countdown and latched redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH_IDLE;
            fcnt_q  <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            redir_q <= redir_d;
        end
    end

    // Enter the flush window on a mispredict, count it down, then go idle.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        redir_d = redir_q;
        unique case (state_q)
            FLUSH_IDLE: begin
                if (mispred) begin
                    state_d = FLUSH_ACTIVE;
                    fcnt_d  = FcW'(FlushLen);
                    redir_d = res_act_taken ? res_target : res_fallthrough;
                end
            end
            FLUSH_ACTIVE: begin
                fcnt_d = fcnt_q - 1'b1;
                if (fcnt_q == FcW'(1)) state_d = FLUSH_IDLE;
            end
            default: begin
                state_d = FLUSH_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // Performance counters; wrap naturally at 2^CntW.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (accept)  br_count      <= br_count + 1'b1;
            if (mispred) mispred_count <= mispred_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_ctrl_bht.sv
// Directed, table-driven bench for branch_ctrl_bht (default build, Depth=64,
// CtrBits=2, FlushLen=2). Each record holds the inputs applied for one cycle
// and the outputs expected during that cycle, before the closing edge.
module tb_branch_ctrl_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid, res_is_branch, res_pred_taken, res_act_taken;
    logic [31:0] res_pc, res_target, res_fallthrough;
    logic        flush;
    logic [31:0] redirect_pc, br_count, mispred_count;

    int total = 0;
    int bad   = 0;

    branch_ctrl_bht dut (
        .clk             (clk),
        .rst             (rst),
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .res_valid       (res_valid),
        .res_is_branch   (res_is_branch),
        .res_pc          (res_pc),
        .res_pred_taken  (res_pred_taken),
        .res_act_taken   (res_act_taken),
        .res_target      (res_target),
        .res_fallthrough (res_fallthrough),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .br_count        (br_count),
        .mispred_count   (mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] pc;
        logic        rv, rb;
        logic [31:0] rpc;
        logic        rp, ra;
        logic [31:0] tgt, fall;
        logic        e_pred, e_flush;
        logic [31:0] e_redir, e_br, e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic r, logic [31:0] pc,
                                logic rv, logic rb, logic [31:0] rpc, logic rp, logic ra,
                                logic [31:0] tgt, logic [31:0] fall,
                                logic e_pred, logic e_flush, logic [31:0] e_redir,
                                logic [31:0] e_br, logic [31:0] e_mis);
        vec_t v;
        v.name = name; v.rst = r; v.pc = pc; v.rv = rv; v.rb = rb; v.rpc = rpc;
        v.rp = rp; v.ra = ra; v.tgt = tgt; v.fall = fall; v.e_pred = e_pred;
        v.e_flush = e_flush; v.e_redir = e_redir; v.e_br = e_br; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(string name, string what, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s: got %0h want %0h", name, what, got, want);
        end
    endtask

    task automatic step(vec_t v);
        rst = v.rst; pred_pc = v.pc; res_valid = v.rv; res_is_branch = v.rb;
        res_pc = v.rpc; res_pred_taken = v.rp; res_act_taken = v.ra;
        res_target = v.tgt; res_fallthrough = v.fall;
        @(negedge clk);
        chk(v.name, "pred_taken",    32'(pred_taken),  32'(v.e_pred));
        chk(v.name, "flush",         32'(flush),       32'(v.e_flush));
        chk(v.name, "redirect_pc",   redirect_pc,      v.e_redir);
        chk(v.name, "br_count",      br_count,         v.e_br);
        chk(v.name, "mispred_count", mispred_count,    v.e_mis);
        @(posedge clk); #1;
    endtask

    initial begin
        // Main table: train 0x100, saturation on 0x208, non-branch, aliasing, same-cycle r/w.
        tbl.push_back(mk("reset",   0, 32'h100, 0,0,0,         0,0, 0,0,        0,0,32'h000, 0,0));
        tbl.push_back(mk("mis1",    0, 32'h100, 1,1,32'h100,   0,1, 32'h140,32'h104, 0,0,32'h000, 0,0));
        tbl.push_back(mk("fl_c1",   0, 32'h100, 0,0,0,         0,0, 0,0,        1,1,32'h140, 1,1));
        tbl.push_back(mk("fl_c2",   0, 32'h100, 0,0,0,         0,0, 0,0,        1,1,32'h140, 1,1));
        tbl.push_back(mk("hit2",    0, 32'h100, 1,1,32'h100,   1,1, 32'h140,32'h104, 1,0,32'h140, 1,1));
        tbl.push_back(mk("after2",  0, 32'h100, 0,0,0,         0,0, 0,0,        1,0,32'h140, 2,1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("nt_sat", 0, 32'h208, 1,1,32'h208, 0,0, 32'h300,32'h20c,
                             0,0,32'h140, 32'(2+i),1));
        tbl.push_back(mk("tk1",     0, 32'h208, 1,1,32'h208,   1,1, 32'h300,32'h20c, 0,0,32'h140, 7,1));
        tbl.push_back(mk("tk2",     0, 32'h208, 1,1,32'h208,   1,1, 32'h300,32'h20c, 0,0,32'h140, 8,1));
        tbl.push_back(mk("tk3",     0, 32'h208, 1,1,32'h208,   1,1, 32'h300,32'h20c, 1,0,32'h140, 9,1));
        tbl.push_back(mk("tk4",     0, 32'h208, 1,1,32'h208,   1,1, 32'h300,32'h20c, 1,0,32'h140, 10,1));
        tbl.push_back(mk("tk5_sat", 0, 32'h208, 1,1,32'h208,   1,1, 32'h300,32'h20c, 1,0,32'h140, 11,1));
        tbl.push_back(mk("no_wrap", 0, 32'h208, 0,0,0,         0,0, 0,0,        1,0,32'h140, 12,1));
        tbl.push_back(mk("nonbr",   0, 32'h208, 1,0,32'h208,   1,0, 32'h300,32'h20c, 1,0,32'h140, 12,1));
        tbl.push_back(mk("nonbr_q", 0, 32'h208, 0,0,0,         0,0, 0,0,        1,0,32'h140, 12,1));
        tbl.push_back(mk("alias0",  0, 32'h000, 0,0,0,         0,0, 0,0,        1,0,32'h140, 12,1));
        tbl.push_back(mk("pc4",     0, 32'h004, 0,0,0,         0,0, 0,0,        0,0,32'h140, 12,1));
        tbl.push_back(mk("rw_same", 0, 32'h004, 1,1,32'h004,   1,1, 32'h040,32'h008, 0,0,32'h140, 12,1));
        tbl.push_back(mk("rw_next", 0, 32'h004, 0,0,0,         0,0, 0,0,        1,0,32'h140, 13,1));

        rst = 1'b1; pred_pc = '0; res_valid = 0; res_is_branch = 0; res_pc = '0;
        res_pred_taken = 0; res_act_taken = 0; res_target = '0; res_fallthrough = '0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // Squash: mispredict then two more would-be mispredicts inside the window.
        step(mk("sq_mis",   0, 32'h010, 1,1,32'h010, 1,0, 32'h500,32'h014, 0,0,32'h140, 13,1));
        step(mk("sq_n1",    0, 32'h010, 1,1,32'h010, 0,1, 32'h600,32'h014, 0,1,32'h014, 14,2));
        step(mk("sq_n2",    0, 32'h010, 1,1,32'h010, 0,1, 32'h600,32'h014, 0,1,32'h014, 14,2));
        step(mk("sq_end",   0, 32'h010, 0,0,0,       0,0, 0,0,             0,0,32'h014, 14,2));
        step(mk("sq_tbl",   0, 32'h010, 1,1,32'h010, 1,1, 32'h600,32'h014, 0,0,32'h014, 14,2));
        step(mk("sq_tbl2",  0, 32'h010, 0,0,0,       0,0, 0,0,             0,0,32'h014, 15,2));

        // Reset while flushing aborts the window and re-initialises the table.
        step(mk("rs_mis",   0, 32'h010, 1,1,32'h010, 0,1, 32'h700,32'h014, 0,0,32'h014, 15,2));
        step(mk("rs_fl",    1, 32'h010, 0,0,0,       0,0, 0,0,             1,1,32'h700, 16,3));
        step(mk("rs_after", 0, 32'h010, 0,0,0,       0,0, 0,0,             0,0,32'h000, 0,0));
        step(mk("rs_idx0",  0, 32'h100, 0,0,0,       0,0, 0,0,             0,0,32'h000, 0,0));
        step(mk("rs_idx2",  0, 32'h208, 0,0,0,       0,0, 0,0,             0,0,32'h000, 0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
